fetch_ctrl: RTL and testbench

//  Program-counter and fetch sequencer for the 9-bit core; sits directly upstream of

---
 rtl/core_pkg.sv | 19 +
 rtl/pc_lut.sv | 19 +
 rtl/fetch_ctrl.sv | 107 ++++++++++
 tb/tb_fetch_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared constants and types for the 9-bit core.
//   PC_W        program counter width (instruction ROM depth = 2**PC_W)
//   INSTR_W     instruction word width
//   LUT_W       branch-index width into the target LUT
//   DONE_INSTR  instruction encoding that halts the core
//   fetch_state_t  fetch sequencer states
//   pc_t           program counter type at the default width
package core_pkg;

    localparam int PC_W    = 10;
    localparam int INSTR_W = 9;
    localparam int LUT_W   = 5;
    localparam logic [INSTR_W-1:0] DONE_INSTR = 9'h0FF;

    typedef enum logic [1:0] {FS_IDLE, FS_RUN, FS_DONE} fetch_state_t;

    typedef logic [PC_W-1:0] pc_t;

endpackage

// File: rtl/pc_lut.sv
// Branch target lookup: combinational ROM mapping a branch index to an
// absolute PC_W-bit target. Contents come from the assembler-generated
// table, handed in as one packed vector (entry i at bits [i*PC_W +: PC_W]).
//   idx     in   LUT_W   branch index
//   target  out  PC_W    absolute branch target
module pc_lut #(
    parameter int PC_W  = 10,
    parameter int LUT_W = 5,
    parameter logic [(2**LUT_W)*PC_W-1:0] LUT_INIT = '0
) (
    input  logic [LUT_W-1:0] idx,
    output logic [PC_W-1:0]  target
);

    always_comb begin
        target = LUT_INIT[int'(idx)*PC_W +: PC_W];
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Program-counter and fetch sequencer for the 9-bit core.
// Owns ProgCtr, applies branches through the target LUT, honours decoder
// stalls and raises Done on the halt word or when the PC would run off
// the end of the instruction ROM.
//   Clk          in   1        system clock, rising edge
//   Reset        in   1        asynchronous, active-high reset
//   InstrIn      in   INSTR_W  ROM word addressed by ProgCtr (same cycle)
//   Stall        in   1        decoder hold request, PC frozen while high
//   BranchTaken  in   1        branch condition true for current instruction
//   BranchIdx    in   LUT_W    LUT index of branch target
//   ProgCtr      out  PC_W     address to instruction ROM
//   InstrValid   out  1        InstrIn is a live instruction this cycle
//   Done         out  1        program finished (sticky until Reset)
//   Overrun      out  1        finished because PC ran off the ROM (sticky)
//
// state   | meaning
// FS_IDLE | out of reset, ROM gets one cycle before the first fetch
// FS_RUN  | fetching, PC advances / branches / holds each edge
// FS_DONE | halted or overran, absorbing until Reset
module fetch_ctrl #(
    parameter int PC_W    = core_pkg::PC_W,
    parameter int INSTR_W = core_pkg::INSTR_W,
    parameter int LUT_W   = core_pkg::LUT_W,
    parameter logic [INSTR_W-1:0] DONE_INSTR = core_pkg::DONE_INSTR,
    parameter logic [(2**LUT_W)*PC_W-1:0] LUT_INIT = '0
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic [INSTR_W-1:0] InstrIn,
    input  logic               Stall,
    input  logic               BranchTaken,
    input  logic [LUT_W-1:0]   BranchIdx,
    output logic [PC_W-1:0]    ProgCtr,
    output logic               InstrValid,
    output logic               Done,
    output logic               Overrun
);

    import core_pkg::fetch_state_t;
    import core_pkg::FS_IDLE;
    import core_pkg::FS_RUN;
    import core_pkg::FS_DONE;

    localparam logic [PC_W-1:0] PC_LAST = '1;

    fetch_state_t    state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            overrun_q, overrun_d;
    logic [PC_W-1:0] lut_target;

    pc_lut #(
        .PC_W    (PC_W),
        .LUT_W   (LUT_W),
        .LUT_INIT(LUT_INIT)
    ) LUT1 (
        .idx   (BranchIdx),
        .target(lut_target)
    );

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q   <= FS_IDLE;
            pc_q      <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            overrun_q <= overrun_d;
        end
    end

    // Halt word beats stall, stall beats branch, branch beats increment.
    // Overrun only applies to the increment path; a branch from the last
    // address is a normal branch.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        overrun_d = overrun_q;
        case (state_q)
            FS_IDLE: state_d = FS_RUN;
            FS_RUN: begin
                if (InstrIn == DONE_INSTR) begin
                    state_d = FS_DONE;
                end else if (Stall) begin
                    pc_d = pc_q;
                end else if (BranchTaken) begin
                    pc_d = lut_target;
                end else if (pc_q == PC_LAST) begin
                    state_d   = FS_DONE;
                    overrun_d = 1'b1;
                end else begin
                    pc_d = pc_q + 1'b1;
                end
            end
            FS_DONE: state_d = FS_DONE;
            default: state_d = FS_IDLE;
        endcase
    end

    always_comb begin
        ProgCtr    = pc_q;
        InstrValid = (state_q == FS_RUN);
        Done       = (state_q == FS_DONE);
        Overrun    = overrun_q;
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
module tb_fetch_ctrl;

    // ---------------- LUT contents ----------------
    function automatic logic [9:0] lut_a_val(int i);
        if (i == 3)  return 10'd5;
        if (i == 0)  return 10'd0;
        if (i == 31) return 10'd1023;
        return 10'((i * 37 + 11) % 1024);
    endfunction

    function automatic logic [3:0] lut_b_val(int i);
        return 4'(i % 16);
    endfunction

    function automatic logic [32*10-1:0] mk_lut_a();
        logic [32*10-1:0] r;
        r = '0;
        for (int i = 0; i < 32; i++) r[i*10 +: 10] = lut_a_val(i);
        return r;
    endfunction

    function automatic logic [32*4-1:0] mk_lut_b();
        logic [32*4-1:0] r;
        r = '0;
        for (int i = 0; i < 32; i++) r[i*4 +: 4] = lut_b_val(i);
        return r;
    endfunction

    localparam logic [32*10-1:0] LUT_A = mk_lut_a();
    localparam logic [32*4-1:0]  LUT_B = mk_lut_b();

    // ---------------- signals ----------------
    logic       clk;
    logic       reset_a, reset_b;
    logic [8:0] instr_a, instr_b;
    logic       stall_a, br_a, stall_b, br_b;
    logic [4:0] idx_a, idx_b;
    logic [9:0] pc_a;
    logic [3:0] pc_b;
    logic       valid_a, done_a, over_a;
    logic       valid_b, done_b, over_b;

    logic [8:0] rom_a [1024];

    always_comb instr_a = rom_a[pc_a];

    fetch_ctrl #(
        .PC_W(10), .INSTR_W(9), .LUT_W(5), .DONE_INSTR(9'h0FF), .LUT_INIT(LUT_A)
    ) f0 (
        .Clk(clk), .Reset(reset_a), .InstrIn(instr_a), .Stall(stall_a),
        .BranchTaken(br_a), .BranchIdx(idx_a), .ProgCtr(pc_a),
        .InstrValid(valid_a), .Done(done_a), .Overrun(over_a)
    );

    fetch_ctrl #(
        .PC_W(4), .INSTR_W(9), .LUT_W(5), .DONE_INSTR(9'h0FF), .LUT_INIT(LUT_B)
    ) f1 (
        .Clk(clk), .Reset(reset_b), .InstrIn(instr_b), .Stall(stall_b),
        .BranchTaken(br_b), .BranchIdx(idx_b), .ProgCtr(pc_b),
        .InstrValid(valid_b), .Done(done_b), .Overrun(over_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(string nm, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model for f0 ----------------
    // Phases: not started (first edge only starts), running, finished.
    int m_pc;
    bit m_started, m_finished, m_over;

    task automatic model_reset();
        m_pc = 0; m_started = 0; m_finished = 0; m_over = 0;
    endtask

    task automatic model_edge(int instr, bit st, bit br, int target, int pc_max);
        if (m_finished) return;
        if (!m_started) begin
            m_started = 1;
            return;
        end
        if (instr == 255) m_finished = 1;
        else if (st) m_pc = m_pc;
        else if (br) m_pc = target;
        else if (m_pc + 1 > pc_max) begin
            m_finished = 1;
            m_over = 1;
        end else m_pc = m_pc + 1;
    endtask

    task automatic model_check(string tag);
        chk({tag, " pc"},    int'(pc_a),    m_pc);
        chk({tag, " valid"}, int'(valid_a), int'(m_started && !m_finished));
        chk({tag, " done"},  int'(done_a),  int'(m_finished));
        chk({tag, " over"},  int'(over_a),  int'(m_over));
    endtask

    task automatic reset_a_seq();
        stall_a = 0; br_a = 0; idx_a = '0;
        reset_a = 1;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset_a = 0;
        chk("rst pc",    int'(pc_a),    0);
        chk("rst valid", int'(valid_a), 0);
        chk("rst done",  int'(done_a),  0);
        chk("rst over",  int'(over_a),  0);
    endtask

    task automatic load_rom(int phase);
        for (int i = 0; i < 1024; i++) rom_a[i] = 9'h001;
        case (phase)
            1: begin rom_a[0] = 9'h001; rom_a[1] = 9'h002; rom_a[2] = 9'h0FF; end
            2: rom_a[6] = 9'h0FF;
            3: rom_a[7] = 9'h0FF;
            default: ;
        endcase
    endtask

    task automatic cyc_a(bit st, bit br, int idx);
        stall_a = st; br_a = br; idx_a = 5'(idx);
        model_edge(int'(rom_a[m_pc]), st, br, int'(lut_a_val(idx)), 1023);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic edge_b(bit st, bit br, int idx);
        stall_b = st; br_b = br; idx_b = 5'(idx);
        @(posedge clk);
        @(negedge clk);
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        int phase;
        bit st;
        bit br;
        int idx;
        int pc;
        bit valid;
        bit done;
    } vec_t;

    vec_t vecs[$];

    initial begin
        int prev_phase;
        int run_pc;
        reset_a = 1; reset_b = 1;
        stall_a = 0; br_a = 0; idx_a = '0;
        stall_b = 0; br_b = 0; idx_b = '0; instr_b = 9'h001;
        load_rom(0);
        model_reset();

        // phase 1: short program ending in halt word
        vecs.push_back('{1, 0, 0, 0, 0, 1, 0});
        vecs.push_back('{1, 0, 0, 0, 1, 1, 0});
        vecs.push_back('{1, 0, 0, 0, 2, 1, 0});
        vecs.push_back('{1, 0, 0, 0, 2, 0, 1});
        vecs.push_back('{1, 1, 1, 3, 2, 0, 1});
        // phase 2: branch at PC=1 through lut[3]=5, halt at 6
        vecs.push_back('{2, 0, 0, 0, 0, 1, 0});
        vecs.push_back('{2, 0, 0, 0, 1, 1, 0});
        vecs.push_back('{2, 0, 1, 3, 5, 1, 0});
        vecs.push_back('{2, 0, 0, 0, 6, 1, 0});
        vecs.push_back('{2, 0, 0, 0, 6, 0, 1});
        // phase 3: stall+branch at PC=4 for 3 cycles, then halt under stall at 7
        vecs.push_back('{3, 0, 0, 0, 0, 1, 0});
        vecs.push_back('{3, 0, 0, 0, 1, 1, 0});
        vecs.push_back('{3, 0, 0, 0, 2, 1, 0});
        vecs.push_back('{3, 0, 0, 0, 3, 1, 0});
        vecs.push_back('{3, 0, 0, 0, 4, 1, 0});
        vecs.push_back('{3, 1, 1, 3, 4, 1, 0});
        vecs.push_back('{3, 1, 1, 3, 4, 1, 0});
        vecs.push_back('{3, 1, 1, 3, 4, 1, 0});
        vecs.push_back('{3, 0, 1, 3, 5, 1, 0});
        vecs.push_back('{3, 0, 0, 0, 6, 1, 0});
        vecs.push_back('{3, 0, 0, 0, 7, 1, 0});
        vecs.push_back('{3, 1, 1, 3, 7, 0, 1});

        @(negedge clk);
        reset_b = 0;
        prev_phase = 0;
        foreach (vecs[k]) begin
            if (vecs[k].phase != prev_phase) begin
                load_rom(vecs[k].phase);
                reset_a_seq();
                prev_phase = vecs[k].phase;
            end
            stall_a = vecs[k].st; br_a = vecs[k].br; idx_a = 5'(vecs[k].idx);
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("vec%0d pc", k),    int'(pc_a),    vecs[k].pc);
            chk($sformatf("vec%0d valid", k), int'(valid_a), int'(vecs[k].valid));
            chk($sformatf("vec%0d done", k),  int'(done_a),  int'(vecs[k].done));
            chk($sformatf("vec%0d over", k),  int'(over_a),  0);
        end

        // post-done: inputs toggled, outputs frozen at PC=7
        for (int c = 0; c < 10; c++) begin
            stall_a = 1'($urandom_range(0, 1));
            br_a    = 1'($urandom_range(0, 1));
            idx_a   = 5'($urandom_range(0, 31));
            rom_a[7] = 9'($urandom_range(0, 511));
            @(posedge clk);
            @(negedge clk);
            chk("postdone pc",    int'(pc_a),    7);
            chk("postdone done",  int'(done_a),  1);
            chk("postdone valid", int'(valid_a), 0);
            chk("postdone over",  int'(over_a),  0);
        end

        // reset mid-run at PC=7 with a branch pending
        load_rom(0);
        reset_a_seq();
        for (int c = 0; c < 8; c++) cyc_a(0, 0, 0);
        chk("midrst pre pc", int'(pc_a), 7);
        stall_a = 0; br_a = 1; idx_a = 5'd3;
        #2;
        reset_a = 1;
        #1;
        chk("midrst async pc",    int'(pc_a),    0);
        chk("midrst async valid", int'(valid_a), 0);
        chk("midrst async done",  int'(done_a),  0);
        chk("midrst async over",  int'(over_a),  0);
        @(negedge clk);
        br_a = 0;
        reset_a = 0;
        model_reset();
        cyc_a(0, 0, 0);
        chk("midrst restart pc",    int'(pc_a),    0);
        chk("midrst restart valid", int'(valid_a), 1);
        cyc_a(0, 0, 0);
        chk("midrst restart pc1",   int'(pc_a),    1);

        // overrun on the 4-bit instance
        reset_b = 1;
        @(negedge clk);
        reset_b = 0;
        for (int k = 1; k <= 16; k++) begin
            edge_b(0, 0, 0);
            chk($sformatf("ovr edge%0d pc", k), int'(pc_b), k - 1);
            chk($sformatf("ovr edge%0d done", k), int'(done_b), 0);
        end
        edge_b(0, 0, 0);
        chk("ovr pc",    int'(pc_b),    15);
        chk("ovr done",  int'(done_b),  1);
        chk("ovr flag",  int'(over_b),  1);
        chk("ovr valid", int'(valid_b), 0);
        for (int c = 0; c < 10; c++) begin
            instr_b = 9'($urandom_range(0, 511));
            edge_b(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 31));
            chk("ovr hold pc",   int'(pc_b),   15);
            chk("ovr hold done", int'(done_b), 1);
            chk("ovr hold flag", int'(over_b), 1);
        end
        instr_b = 9'h001;

        // branch from the last address is not an overrun
        reset_b = 1;
        @(negedge clk);
        reset_b = 0;
        for (int k = 1; k <= 16; k++) edge_b(0, 0, 0);
        edge_b(0, 1, 3);
        chk("lastbr pc",    int'(pc_b),    int'(lut_b_val(3)));
        chk("lastbr done",  int'(done_b),  0);
        chk("lastbr over",  int'(over_b),  0);
        chk("lastbr valid", int'(valid_b), 1);
        edge_b(0, 0, 0);
        chk("lastbr next pc", int'(pc_b), int'(lut_b_val(3)) + 1);

        // randomized runs against the reference model
        for (int r = 0; r < 10; r++) begin
            for (int i = 0; i < 1024; i++) begin
                if ($urandom_range(0, 15) == 0) rom_a[i] = 9'h0FF;
                else rom_a[i] = 9'($urandom_range(0, 511));
            end
            reset_a_seq();
            run_pc = 0;
            for (int c = 0; c < 300; c++) begin
                cyc_a($urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0,
                      $urandom_range(0, 31));
                model_check($sformatf("rnd%0d", r));
                if (m_finished) run_pc++;
                if (run_pc > 3) break;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
